// File: rtl/phy_stats_regs.sv
// Statistics register block: syncs gray-coded PHY frame counters into clk and
// extends them into clearable accumulators on the iomem bus. Optional: STATS_SNAPSHOT_EN.
module phy_stats_regs #(
  parameter int unsigned PHY_NUM   = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ACC_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PHY_NUM*CNT_W-1:0] rx_succ_gray,
  input  logic [PHY_NUM*CNT_W-1:0] rx_of_gray,
  input  logic [PHY_NUM*CNT_W-1:0] tx_succ_gray,
  input  logic [PHY_NUM*CNT_W-1:0] tx_fail_gray,
  input  logic                     iomem_valid,
  input  logic [3:0]               iomem_wstrb,
  input  logic [31:0]              iomem_addr,
  input  logic [31:0]              iomem_wdata,
  output logic                     iomem_ready,
  output logic [31:0]              iomem_rdata
);

  localparam int unsigned N     = 4 * PHY_NUM;
  localparam int unsigned IDX_W = $clog2(N);

  typedef enum logic {PRIME, RUN} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       fill_q;
  logic             scan_en;

  logic [CNT_W-1:0] gray_in [N];
  logic [CNT_W-1:0] s1_q    [N];
  logic [CNT_W-1:0] s2_q    [N];
  logic [CNT_W-1:0] bin_q   [N];
  logic [CNT_W-1:0] prev_q  [N];
  logic [ACC_W-1:0] acc_q   [N];

  logic [CNT_W-1:0] bin_sel, delta;
  logic [ACC_W-1:0] acc_sum;

  logic [31:0]      offset, rd_val;
  logic [IDX_W-1:0] bus_k;
  logic             cnt_hit, ctrl_hit, req, wr, clr;
  logic             unused_wdata;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b[CNT_W-1] = g[CNT_W-1];
    for (int unsigned i = 1; i < CNT_W; i++)
      b[CNT_W-1-i] = b[CNT_W-i] ^ g[CNT_W-1-i];
    return b;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < N; k++) gray_in[k] = '0;
    for (int unsigned p = 0; p < PHY_NUM; p++) begin
      gray_in[4*p]   = rx_succ_gray[p*CNT_W +: CNT_W];
      gray_in[4*p+1] = rx_of_gray[p*CNT_W +: CNT_W];
      gray_in[4*p+2] = tx_succ_gray[p*CNT_W +: CNT_W];
      gray_in[4*p+3] = tx_fail_gray[p*CNT_W +: CNT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        s1_q[k]  <= '0;
        s2_q[k]  <= '0;
        bin_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        s1_q[k]  <= gray_in[k];
        s2_q[k]  <= s1_q[k];
        bin_q[k] <= gray2bin(s2_q[k]);
      end
    end
  end

  // Scanner stalls at k=0 until the 3-deep sync/convert pipe holds real input,
  // so PRIME never latches the post-reset zeros as a baseline.
  assign scan_en = (fill_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= PRIME;
      idx_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (!scan_en) fill_q <= fill_q + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (scan_en) begin
      idx_d = (idx_q == IDX_W'(N-1)) ? '0 : idx_q + 1'b1;
      if (state_q == PRIME && idx_q == IDX_W'(N-1)) state_d = RUN;
    end
  end

  assign bin_sel = bin_q[idx_q];
  assign delta   = bin_sel - prev_q[idx_q];
  assign acc_sum = acc_q[idx_q] + ACC_W'(delta);

  assign offset  = iomem_addr - BASE_ADDR;
  assign cnt_hit = (offset[31:8] < 24'(PHY_NUM)) && (offset[7:4] == 4'd0) &&
                   (offset[1:0] == 2'd0);
  assign bus_k   = IDX_W'({offset[31:8], offset[3:2]});
  assign wr      = |iomem_wstrb;
  assign req     = iomem_valid && !iomem_ready && (cnt_hit || ctrl_hit);
  assign clr     = req && wr && cnt_hit;
  assign unused_wdata = ^iomem_wdata;

`ifdef STATS_SNAPSHOT_EN
  logic [ACC_W-1:0] shadow_q [N];

  assign ctrl_hit = (offset == 32'h0000_1000);
  assign rd_val   = ctrl_hit ? 32'h1 : 32'(shadow_q[bus_k]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) shadow_q[k] <= '0;
    end else if (req && wr && ctrl_hit && iomem_wdata[0]) begin
      for (int unsigned k = 0; k < N; k++) shadow_q[k] <= acc_q[k];
    end
  end
`else
  assign ctrl_hit = 1'b0;
  assign rd_val   = 32'(acc_q[bus_k]);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < N; k++) begin
        acc_q[k]  <= '0;
        prev_q[k] <= '0;
      end
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= req;
      if (req) iomem_rdata <= wr ? '0 : rd_val;
      if (scan_en) begin
        prev_q[idx_q] <= bin_sel;
        if (state_q == RUN) acc_q[idx_q] <= acc_sum;
      end
      // Later assignment wins: a clear discards a same-cycle scanner delta.
      if (clr) acc_q[bus_k] <= '0;
    end
  end

endmodule

// File: doc/phy_stats_regs.md
Name: phy_stats_regs

Overview:
- Memory-mapped statistics peripheral on the picosoc iomem bus.
- Consumes the 16-bit gray-coded RX/TX frame counters from every RMII_RX/RMII_TX instance, which run in PHY_REF_CLK domains.
- Synchronises the counters into clk, converts them to binary, and extends each into a 32-bit clearable accumulator.
- Serves reads and clear-writes to firmware; replaces the ad-hoc iomem decode in the switch top level.

Parameters:
PHY_NUM, 4, number of PHY ports monitored.
BASE_ADDR, 32'h0300_0000, base of register window (must be 64 KiB aligned).
CNT_W, 16, width of incoming gray counters.
ACC_W, 32, width of accumulators (must be >= CNT_W, <= 32).

Ports:
clk  input  1  system clock (100 MHz).
rst_n  input  1  reset; synchronous, active-low.
rx_succ_gray  input  PHY_NUM*CNT_W  RX success counters, port p at [p*CNT_W +: CNT_W].
rx_of_gray  input  PHY_NUM*CNT_W  RX buffer-overflow counters, same packing.
tx_succ_gray  input  PHY_NUM*CNT_W  TX success counters.
tx_fail_gray  input  PHY_NUM*CNT_W  TX fail counters.
iomem_valid  input  1  bus request.
iomem_wstrb  input  4  byte strobes; 0 = read, nonzero = write.
iomem_addr  input  32  byte address.
iomem_wdata  input  32  write data.
iomem_ready  output  1  one-cycle response pulse.
iomem_rdata  output  32  read data, valid while iomem_ready=1.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all state:
  - iomem_ready=0, iomem_rdata=0.
  - Accumulators, prev registers and sync flops = 0.
  - Scanner index = 0, FSM = PRIME.
- Sync: each gray input bit passes through two clk flops. Gray->binary conversion is registered: 1 cycle. Total 3 cycles from input change to binary value.
- Counter index k = 4*p + t:
  - p = port; t: 0 rx_succ, 1 rx_of, 2 tx_succ, 3 tx_fail.
  - N = 4*PHY_NUM counters in total.
- Scanner visits one counter per cycle, k = 0..N-1, then wraps to 0. One shared subtract/add datapath.
- FSM:
  - PRIME: prev[k] <= bin[k]; accumulator untouched. Goes to RUN after k = N-1 has been visited.
  - RUN: delta = (bin[k] - prev[k]) mod 2^CNT_W; acc[k] <= acc[k] + delta, mod 2^ACC_W (wraps, no saturation); prev[k] <= bin[k].
- Counter wrap 16'hFFFF -> 16'h0002 gives delta 3. A source increment of up to 2^CNT_W-1 within one scan period is counted exactly.
- Address decode: offset = addr - BASE_ADDR.
  - Mapped iff offset = p*0x100 + t*4 with p < PHY_NUM, t < 4.
  - Register value is acc[4p+t].
- Handshake:
  - On a cycle with iomem_valid=1, iomem_ready=0 and a mapped address, the next cycle drives iomem_ready=1 for exactly one cycle.
  - iomem_ready always returns to 0 the cycle after it pulses.
  - Unmapped addresses never assert iomem_ready; another slave answers.
- Read (wstrb=0): iomem_rdata <= acc value, native bit order, no byte swap. iomem_rdata holds until the next response.
- Write (wstrb!=0): acc[k] <= 0 regardless of wdata or strobes; iomem_rdata <= 0.
- Same-cycle scanner update and clear of the same k: clear wins (acc=0); prev still updates, so that delta is discarded.
- Same-cycle scanner update and read of the same k: read returns the pre-update value.
- Reset mid-transaction: iomem_ready is forced to 0 and the request is dropped. The FSM re-enters PRIME, so accumulators restart from 0 without absorbing the counters' absolute values.

Optional Feature:
- Macro STATS_SNAPSHOT_EN.
- Defined:
  - Control register at offset 0x1000. A write with iomem_wdata[0]=1 copies all N accumulators into shadow registers in the same cycle; the response follows the normal handshake.
  - Reads of counter offsets return shadow values; clear-writes still clear the live accumulator only.
  - A read of 0x1000 returns 32'h1. Shadows reset to 0.
- Not defined: offset 0x1000 is unmapped (no ready); reads return live accumulators.

Test Plan:
- Reset, all gray inputs held at gray(100), 2*N cycles elapsed, read 0x0300_0000 -> ready pulse 1 cycle after valid, rdata=0 (PRIME absorbed 100).
- Step port 2 tx_succ through gray(100..105), wait 3+N cycles, read 0x0300_0208 -> rdata=5; other 15 counters read 0.
- Port 1 rx_of at gray(16'hFFFE), then step to gray(16'h0003), wait 3+N cycles, read 0x0300_0104 -> rdata=5 (wrap handled).
- Write 32'hDEAD_BEEF with wstrb=4'hF to 0x0300_0208, then read -> write ready pulse, subsequent rdata=0. Issue the clear on the scanner's k=10 cycle with pending delta 2 -> rdata=0, and a later +1 reads 1.
- Read 0x0300_0010 and 0x0300_0400 -> iomem_ready stays 0 for 20 cycles; assert rst_n=0 during an outstanding valid -> iomem_ready=0 next cycle.
- STATS_SNAPSHOT_EN: accumulate port 0 rx_succ to 7, write 1 to 0x0300_1000, add 3 more, read 0x0300_0000 -> 7. Snapshot again, read -> 10. Read 0x0300_1000 -> 1.
